dense_layer: RTL and testbench
==============================

DENSE_LAYER -- requirements
Module: dense_layer

Interface
REQ-001 Parameters (name, default, meaning), the block SHALL provide:
- INBITS, 8, signed width of each input activation.
- WBITS, 8, signed width of each weight.
- ACCBITS, 24, signed width of accumulator, bias and output.
- IN_SIZE, 16, number of input activations.
- OUT_SIZE, 10, number of neurons (outputs).
- AW, max(1, ceil(log2(IN_SIZE*OUT_SIZE))), weight address width.
REQ-002 Ports (name, direction, width, meaning), the block SHALL provide:
- clk, in, 1, the single clock; all state on its rising edge.
- reset, in, 1, asynchronous, active-high; clears all state immediately.
- start, in, 1, one-cycle request to begin a layer evaluation.
- x, in, INBITS x [0:IN_SIZE-1], signed input vector.
- b, in, ACCBITS x [0:OUT_SIZE-1], signed bias vector, held stable while busy.
- w_addr, out, AW, weight memory read address.
- w_data, in, WBITS, signed weight; valid exactly one cycle after w_addr is presented.
- y, out, ACCBITS x [0:OUT_SIZE-1], signed pre-activation outputs, consumed by the downstream ReLu stage.
- busy, out, 1, high while an evaluation is in progress.
- done, out, 1, high once all OUT_SIZE outputs are valid.

Function
REQ-003 Weight layout SHALL be row-major: weight for neuron j, input i is at address j*IN_SIZE+i.
REQ-004 The block SHALL compute y[j] = b[j] + sum over i of x[i]*w(j,i), as signed arithmetic.
REQ-005 The FSM SHALL have the states IDLE, FILL, MAC and DONE.
REQ-006 In IDLE or DONE, start=1 SHALL latch x into an internal copy, set j=0, i=0, w_addr=0, acc=b[0], busy=1, done=0, and go to FILL.
REQ-007 FILL SHALL last one cycle, present w_addr=j*IN_SIZE+1 (when IN_SIZE>1), and go to MAC.
REQ-008 MAC SHALL last IN_SIZE cycles per neuron; cycle k (k=1..IN_SIZE) SHALL add w_data*x_latched[k-1] to acc and present the next address.
REQ-009 The product SHALL be full-width (INBITS+WBITS bits), sign-extended to ACCBITS.
REQ-010 Each addition SHALL saturate to [-2^(ACCBITS-1), 2^(ACCBITS-1)-1]; the accumulator SHALL never wrap.
REQ-011 On the last MAC cycle of neuron j, y[j] SHALL be written with the final saturated sum.
REQ-012 On that same cycle, if j<OUT_SIZE-1: j SHALL increment, acc SHALL load b[j+1], and the FSM SHALL go to FILL; otherwise it SHALL go to DONE.
REQ-013 Entering DONE SHALL set done=1 and busy=0; done SHALL stay high until the next accepted start or reset.
REQ-014 Latency: done SHALL rise OUT_SIZE*(IN_SIZE+1)+1 rising edges after the edge that samples start, counting that edge as edge 1.
REQ-015 start SHALL be ignored while busy=1.
REQ-016 Changes on x after start is accepted SHALL have no effect on the current evaluation.
REQ-017 y[j] SHALL change only on its own write cycle (REQ-011); all other y entries hold their values.
REQ-018 A start accepted in DONE SHALL clear done on the next edge; previous y values SHALL remain until overwritten.
REQ-019 w_addr SHALL never exceed IN_SIZE*OUT_SIZE-1.

Reset
REQ-020 While reset=1, regardless of clk, the block SHALL hold: state=IDLE, all y=0, acc=0, i=j=0, w_addr=0, busy=0, done=0.
REQ-021 Reset asserted mid-evaluation SHALL abort it without writing any further y entry.
REQ-022 After reset deasserts, the block SHALL wait in IDLE for a new start.

Verification (IN_SIZE=4, OUT_SIZE=2, 1-cycle-latency weight memory model)
REQ-023 Reset: assert reset between clock edges -> y={0,0}, busy=0, done=0 immediately, without waiting for a clock edge.
REQ-024 Basic: x={1,2,3,4}, row0 weights {1,1,1,1}, row1 {-1,0,0,0}, b={0,10}, start -> y={10,9}; done rises on edge 11; busy high for edges 1..10.
REQ-025 Saturation (ACCBITS=12): x all 127.
- All w=127, b=0 -> y[0]=2047.
- All w=-128 -> y[1]=-2048.
REQ-026 Start handling:
- start pulsed again on edges 3 and 7 -> ignored; result and timing identical to REQ-024.
- start in DONE -> done drops on the next edge; a new evaluation completes.
REQ-027 Mid-run reset: reset on edge 6 of the REQ-024 run -> all outputs cleared; a fresh start then reproduces y={10,9} with identical timing.

Source files
------------

// File: rtl/dense_layer.sv
// dense_layer: one fully connected layer, one MAC per clock.
//
// Evaluates y[j] = b[j] + sum_i x[i]*w(j,i) for every neuron j in turn,
// reading weights from an external memory with one cycle of read latency.
// The weight for neuron j, input i lives at address j*IN_SIZE+i.
//
// Ports
//   clk     - clock, all state on the rising edge
//   reset   - asynchronous, active-high clear
//   start   - one-cycle request to evaluate the layer (ignored while busy)
//   x       - signed input activations, captured when start is accepted
//   b       - signed biases, held stable by the producer while busy
//   w_addr  - weight memory read address
//   w_data  - weight read back one cycle after w_addr
//   y       - signed pre-activation outputs, one per neuron
//   busy    - evaluation in progress
//   done    - all outputs valid; held until the next accepted start

// Saturating multiply-accumulate: acc + xi*wi, clamped to the ACCBITS range.
// The sum is formed wide enough that neither the product nor the addition
// can overflow before the clamp, even when ACCBITS < INBITS+WBITS.
module dense_layer_sat_mac #(
  parameter int INBITS  = 8,
  parameter int WBITS   = 8,
  parameter int ACCBITS = 24
) (
  input  logic [ACCBITS-1:0] acc,
  input  logic [INBITS-1:0]  xi,
  input  logic [WBITS-1:0]   wi,
  output logic [ACCBITS-1:0] sum_sat
);
  localparam int PW = INBITS + WBITS;
  localparam int SW = ((ACCBITS > PW) ? ACCBITS : PW) + 1;
  localparam logic signed [SW-1:0] SAT_MAX = SW'({1'b0, {(ACCBITS-1){1'b1}}});
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] sum;

  always_comb begin
    prod = PW'($signed(xi)) * PW'($signed(wi));
    sum  = SW'($signed(acc)) + SW'(prod);
    if (sum > SAT_MAX)      sum_sat = {1'b0, {(ACCBITS-1){1'b1}}};
    else if (sum < SAT_MIN) sum_sat = {1'b1, {(ACCBITS-1){1'b0}}};
    else                    sum_sat = sum[ACCBITS-1:0];
  end
endmodule

module dense_layer #(
  parameter int INBITS   = 8,
  parameter int WBITS    = 8,
  parameter int ACCBITS  = 24,
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 10,
  parameter int AW = ($clog2(IN_SIZE*OUT_SIZE) > 1) ? $clog2(IN_SIZE*OUT_SIZE) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [IN_SIZE-1:0][INBITS-1:0]     x,
  input  logic [OUT_SIZE-1:0][ACCBITS-1:0]   b,
  output logic [AW-1:0]                      w_addr,
  input  logic [WBITS-1:0]                   w_data,
  output logic [OUT_SIZE-1:0][ACCBITS-1:0]   y,
  output logic                               busy,
  output logic                               done
);
  localparam int IW = (IN_SIZE  > 1) ? $clog2(IN_SIZE)  : 1;
  localparam int JW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [IW-1:0] I_LAST   = IW'(IN_SIZE - 1);
  localparam logic [JW-1:0] J_LAST   = JW'(OUT_SIZE - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(IN_SIZE);

  typedef enum logic [1:0] {IDLE, FILL, MAC, DONE} state_t;

  state_t                          state, state_d;
  logic [IN_SIZE-1:0][INBITS-1:0]  x_lat;
  logic [ACCBITS-1:0]              acc, acc_next;
  logic [IW-1:0]                   i;
  logic [JW-1:0]                   j, j_nxt;
  logic [AW-1:0]                   row_base;
  logic                            accept, mac_last, neuron_last;

  dense_layer_sat_mac #(
    .INBITS (INBITS),
    .WBITS  (WBITS),
    .ACCBITS(ACCBITS)
  ) u_mac (
    .acc    (acc),
    .xi     (x_lat[i]),
    .wi     (w_data),
    .sum_sat(acc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d     = state;
    accept      = 1'b0;
    mac_last    = (state == MAC) && (i == I_LAST);
    neuron_last = (j == J_LAST);
    j_nxt       = j + JW'(1);
    case (state)
      IDLE, DONE: if (start) begin
        accept  = 1'b1;
        state_d = FILL;
      end
      FILL:       state_d = MAC;
      MAC:        if (i == I_LAST) state_d = neuron_last ? DONE : FILL;
      default:    state_d = IDLE;
    endcase
  end

  assign busy = (state == FILL) || (state == MAC);
  assign done = (state == DONE);

  // Address schedule: w_addr runs one step ahead of the MAC so that w_data
  // for input i arrives on MAC cycle i. FILL covers the first read of each
  // row; the final in-row address is held rather than stepping past the
  // row, and the last MAC cycle jumps to the next row base.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_lat    <= '0;
      acc      <= '0;
      i        <= '0;
      j        <= '0;
      row_base <= '0;
      w_addr   <= '0;
      y        <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (accept) begin
          x_lat    <= x;
          acc      <= b[0];
          i        <= '0;
          j        <= '0;
          row_base <= '0;
          w_addr   <= '0;
        end
        FILL: if (IN_SIZE > 1) w_addr <= w_addr + AW'(1);
        MAC: begin
          if (mac_last) begin
            y[j] <= acc_next;
            i    <= '0;
            if (!neuron_last) begin
              j        <= j_nxt;
              acc      <= b[j_nxt];
              row_base <= row_base + ROW_STEP;
              w_addr   <= row_base + ROW_STEP;
            end else begin
              acc <= acc_next;
            end
          end else begin
            acc <= acc_next;
            i   <= i + IW'(1);
            if (int'(i) + 2 < IN_SIZE) w_addr <= w_addr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dense_layer.sv
// Bench for dense_layer: IN_SIZE=4, OUT_SIZE=2, 12-bit accumulator, with a
// one-cycle-latency weight memory. Expected outputs come from a plain
// integer model of the layer (bias plus products in input order, clamped
// after every addition).
module tb_dense_layer;
  localparam int INB  = 8;
  localparam int WB   = 8;
  localparam int ACCB = 12;
  localparam int NI   = 4;
  localparam int NO   = 2;
  localparam int AWD  = 3;
  localparam int LAT  = NO*(NI+1) + 1;
  localparam int YMAX = 2047;
  localparam int YMIN = -2048;

  logic                      clk = 1'b0;
  logic                      reset, start;
  logic [NI-1:0][INB-1:0]    x;
  logic [NO-1:0][ACCB-1:0]   b, y;
  logic [AWD-1:0]            w_addr;
  logic [WB-1:0]             w_data;
  logic                      busy, done;
  logic [WB-1:0]             mem [0:NI*NO-1];

  int xv[NI];
  int wv[NI*NO];
  int bv[NO];
  int yexp[NO];
  int ycur[NO];
  int checks = 0;
  int errors = 0;

  dense_layer #(
    .INBITS(INB), .WBITS(WB), .ACCBITS(ACCB), .IN_SIZE(NI), .OUT_SIZE(NO), .AW(AWD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .b(b),
    .w_addr(w_addr), .w_data(w_data), .y(y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) w_data <= mem[w_addr];

  task automatic compute_model();
    int s;
    for (int j = 0; j < NO; j++) begin
      s = bv[j];
      for (int i = 0; i < NI; i++) begin
        s = s + xv[i] * wv[j*NI + i];
        if (s > YMAX) s = YMAX;
        else if (s < YMIN) s = YMIN;
      end
      yexp[j] = s;
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NI; i++) x[i] = INB'(xv[i]);
    for (int j = 0; j < NO; j++) b[j] = ACCB'(bv[j]);
    for (int k = 0; k < NI*NO; k++) mem[k] = WB'(wv[k]);
  endtask

  task automatic set_basic();
    xv = '{1, 2, 3, 4};
    wv = '{1, 1, 1, 1, -1, 0, 0, 0};
    bv = '{0, 10};
  endtask

  task automatic check_idle(input string tag);
    for (int j = 0; j < NO; j++) begin
      checks++;
      if (y[j] !== ACCB'(ycur[j])) begin
        errors++;
        $display("FAIL %s y[%0d]: got %0d expected %0d", tag, j, $signed(y[j]), ycur[j]);
      end
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s busy/done: got %b/%b expected 0/0", tag, busy, done);
    end
  endtask

  // One full evaluation. start_mask bit n drives start into edge n (bit 1
  // is the accepting edge). y[j] must hold its old value until edge
  // 1+(j+1)*(NI+1), busy must be high until done rises on edge LAT.
  task automatic do_run(input string tag, input logic [31:0] start_mask, input bit scramble);
    compute_model();
    apply_inputs();
    @(negedge clk);
    start = 1'b1;
    for (int e = 1; e <= LAT + 2; e++) begin
      @(posedge clk);
      #1;
      start = start_mask[e+1];
      if (scramble) x = $urandom;
      for (int j = 0; j < NO; j++)
        if (e == 1 + (j+1)*(NI+1)) ycur[j] = yexp[j];
      for (int j = 0; j < NO; j++) begin
        checks++;
        if (y[j] !== ACCB'(ycur[j])) begin
          errors++;
          $display("FAIL %s y[%0d] edge %0d: got %0d expected %0d", tag, j, e, $signed(y[j]), ycur[j]);
        end
      end
      checks++;
      if (busy !== (e < LAT) || done !== (e >= LAT)) begin
        errors++;
        $display("FAIL %s busy/done edge %0d: got %b/%b expected %b/%b", tag, e, busy, done,
                 (e < LAT), (e >= LAT));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; x = '0; b = '0;
    for (int k = 0; k < NI*NO; k++) mem[k] = '0;
    for (int j = 0; j < NO; j++) ycur[j] = 0;
    #2;
    check_idle("reset_async_initial");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_wait_idle");
    checks++;
    if (w_addr !== '0) begin
      errors++;
      $display("FAIL reset_w_addr: got %0d expected 0", w_addr);
    end
  endtask

  task automatic test_basic();
    set_basic();
    do_run("basic", 32'h0, 1'b0);
  endtask

  task automatic test_start_ignored();
    set_basic();
    do_run("start_ignored", 32'h0000_0088, 1'b0);
  endtask

  task automatic test_saturation();
    xv = '{127, 127, 127, 127};
    wv = '{127, 127, 127, 127, -128, -128, -128, -128};
    bv = '{0, 0};
    do_run("saturation", 32'h0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NI; i++) xv[i] = int'($urandom_range(255)) - 128;
      for (int k = 0; k < NI*NO; k++)
        wv[k] = (r < 3) ? int'($urandom_range(15)) - 8 : int'($urandom_range(255)) - 128;
      for (int j = 0; j < NO; j++) bv[j] = int'($urandom_range(1023)) - 512;
      do_run("random", 32'h0, (r % 2) == 1);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    for (int j = 0; j < NO; j++) ycur[j] = 0;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mid_reset();
    set_basic();
    apply_inputs();
    @(negedge clk);
    start = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < NO; j++) ycur[j] = 0;
    #1;
    check_idle("mid_reset_immediate");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_idle("mid_reset_aborted");
    do_run("mid_reset_rerun", 32'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_saturation();
    test_random();
    test_async_reset();
    test_basic();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
